// File: rtl/bit_sync_filt.sv
// Multi-channel N-flop synchronizer with per-channel stability filter.
// Produces registered clean levels plus single-cycle rise/fall pulses.
module bit_sync_filt #(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH = 4,
  parameter int FILT_CYCLES = 4,
  parameter logic [BUS_WIDTH-1:0] RST_VAL = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] ASYNC,
  input  logic [BUS_WIDTH-1:0] FILT_EN,
  output logic [BUS_WIDTH-1:0] SYNC,
  output logic [BUS_WIDTH-1:0] RISE,
  output logic [BUS_WIDTH-1:0] FALL,
  output logic                 CHG
);

  localparam int CW =
    (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(FILT_CYCLES - 1);

  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("bit_sync_filt: NUM_STAGES must be >= 2");
  end
  if (BUS_WIDTH < 1) begin : g_bad_width
    $error("bit_sync_filt: BUS_WIDTH must be >= 1");
  end
  if (FILT_CYCLES < 1) begin : g_bad_filt
    $error("bit_sync_filt: FILT_CYCLES must be >= 1");
  end

  logic [BUS_WIDTH-1:0] raw;
  logic [BUS_WIDTH-1:0] nxt;
  logic [BUS_WIDTH-1:0] nrise;
  logic [BUS_WIDTH-1:0] nfall;

  for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_ch
    logic [NUM_STAGES-1:0] sq;
    logic [CW-1:0]         cnt;
    logic                  load;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        sq <= {NUM_STAGES{RST_VAL[i]}};
      end else begin
        sq <= {sq[NUM_STAGES-2:0], ASYNC[i]};
      end
    end

    assign raw[i] = sq[NUM_STAGES-1];

    // Bypass loads every cycle; filter loads after a full stable run.
    assign load = !FILT_EN[i] ||
                  ((raw[i] != SYNC[i]) && (cnt == CMAX));
    assign nxt[i] = load ? raw[i] : SYNC[i];

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        cnt <= '0;
      end else if (load || (raw[i] == SYNC[i])) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign nrise = nxt & ~SYNC;
  assign nfall = ~nxt & SYNC;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      SYNC <= RST_VAL;
      RISE <= '0;
      FALL <= '0;
      CHG  <= 1'b0;
    end else begin
      SYNC <= nxt;
      RISE <= nrise;
      FALL <= nfall;
      CHG  <= |(nrise | nfall);
    end
  end

endmodule

// File: tb/tb_bit_sync_filt.sv
// Bench for bit_sync_filt: vector table, directed corner cases,
// and random stimulus against a cycle-level behavioural model.
module tb_bit_sync_filt;

  localparam int NS = 2;
  localparam int FC = 3;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] ASYNC = '0;
  logic [3:0] FILT_EN = '0;
  logic [3:0] SYNC, RISE, FALL;
  logic       CHG;

  bit_sync_filt #(
    .NUM_STAGES(NS),
    .BUS_WIDTH(4),
    .FILT_CYCLES(FC),
    .RST_VAL(4'b0000)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .ASYNC(ASYNC),
    .FILT_EN(FILT_EN),
    .SYNC(SYNC),
    .RISE(RISE),
    .FALL(FALL),
    .CHG(CHG)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  // Model: delay line of sampled inputs plus per-channel run length.
  logic [3:0] hist [NS];
  logic [3:0] m_sync, m_rise, m_fall;
  logic       m_chg;
  int         run [4];

  task automatic model_reset();
    for (int k = 0; k < NS; k++) hist[k] = 4'h0;
    m_sync = 4'h0;
    m_rise = 4'h0;
    m_fall = 4'h0;
    m_chg = 1'b0;
    for (int c = 0; c < 4; c++) run[c] = 0;
  endtask

  task automatic model_edge();
    logic [3:0] r, ns;
    r = hist[NS-1];
    ns = m_sync;
    for (int c = 0; c < 4; c++) begin
      if (!FILT_EN[c]) begin
        ns[c] = r[c];
        run[c] = 0;
      end else if (r[c] == m_sync[c]) begin
        run[c] = 0;
      end else begin
        run[c] = run[c] + 1;
        if (run[c] >= FC) begin
          ns[c] = r[c];
          run[c] = 0;
        end
      end
    end
    m_rise = ns & ~m_sync;
    m_fall = ~ns & m_sync;
    m_chg = (m_rise | m_fall) != 4'h0;
    m_sync = ns;
    for (int k = NS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = ASYNC;
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  function automatic logic [15:0] outs();
    return {3'b0, SYNC, RISE, FALL, CHG};
  endfunction

  function automatic logic [15:0] pk(logic [3:0] s, logic [3:0] r,
                                     logic [3:0] f, logic c);
    return {3'b0, s, r, f, c};
  endfunction

  task automatic do_reset(input logic [3:0] a, input logic [3:0] en);
    ASYNC = a;
    FILT_EN = en;
    RST = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    chk("reset", outs(), pk(4'h0, 4'h0, 4'h0, 1'b0));
    #3;
    RST = 1'b1;
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] en;
    logic [3:0] s;
    logic [3:0] r;
    logic [3:0] f;
    logic       c;
  } vec_t;

  vec_t tv [11];

  initial begin
    // Bypass table: outputs reflect ASYNC applied two rows earlier.
    tv[0]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tv[1]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tv[2]  = '{4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tv[3]  = '{4'h3, 4'h0, 4'h1, 4'h1, 4'h0, 1'b1};
    tv[4]  = '{4'h3, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0};
    tv[5]  = '{4'hC, 4'h0, 4'h3, 4'h2, 4'h0, 1'b1};
    tv[6]  = '{4'hC, 4'h0, 4'h3, 4'h0, 4'h0, 1'b0};
    tv[7]  = '{4'h0, 4'h0, 4'hC, 4'hC, 4'h3, 1'b1};
    tv[8]  = '{4'h0, 4'h0, 4'hC, 4'h0, 4'h0, 1'b0};
    tv[9]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hC, 1'b1};
    tv[10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};

    model_reset();
    #2;
    do_reset(4'h0, 4'h0);
    for (int j = 0; j < 11; j++) begin
      ASYNC = tv[j].a;
      FILT_EN = tv[j].en;
      step();
      chk($sformatf("vec%0d", j), outs(),
          pk(tv[j].s, tv[j].r, tv[j].f, tv[j].c));
    end

    // Filtered rise on channel 1.
    do_reset(4'h0, 4'hF);
    ASYNC = 4'h2;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk($sformatf("filt_wait%0d", j), outs(),
          pk(4'h0, 4'h0, 4'h0, 1'b0));
    end
    step();
    chk("filt_rise", outs(), pk(4'h2, 4'h2, 4'h0, 1'b1));
    step();
    chk("filt_after", outs(), pk(4'h2, 4'h0, 4'h0, 1'b0));

    // Two-cycle glitch on channel 2 is rejected.
    do_reset(4'h0, 4'hF);
    ASYNC = 4'h4;
    for (int j = 0; j < 8; j++) begin
      if (j == 2) ASYNC = 4'h0;
      step();
      chk($sformatf("glitch%0d", j), outs(),
          pk(4'h0, 4'h0, 4'h0, 1'b0));
    end
    // Counter restarted from zero: a held level takes the full latency.
    ASYNC = 4'h4;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk($sformatf("reglitch%0d", j), outs(),
          pk(4'h0, 4'h0, 4'h0, 1'b0));
    end
    step();
    chk("reglitch_rise", outs(), pk(4'h4, 4'h4, 4'h0, 1'b1));

    // Filter disabled mid-count on channel 3.
    do_reset(4'h0, 4'hF);
    ASYNC = 4'h8;
    for (int j = 1; j <= 3; j++) begin
      step();
      chk($sformatf("dis_wait%0d", j), outs(),
          pk(4'h0, 4'h0, 4'h0, 1'b0));
    end
    FILT_EN = 4'h7;
    step();
    chk("dis_rise", outs(), pk(4'h8, 4'h8, 4'h0, 1'b1));
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("dis_after%0d", j), outs(),
          pk(4'h8, 4'h0, 4'h0, 1'b0));
    end

    // Reset while channel 0 pulses and channel 1 is counting.
    do_reset(4'h0, 4'hE);
    ASYNC = 4'h3;
    for (int j = 1; j <= 3; j++) step();
    chk("pre_rst", outs(), pk(4'h1, 4'h1, 4'h0, 1'b1));
    RST = 1'b0;
    #1;
    chk("mid_rst", outs(), pk(4'h0, 4'h0, 4'h0, 1'b0));
    ASYNC = 4'hF;
    FILT_EN = 4'h0;
    model_reset();
    @(posedge CLK);
    #4;
    RST = 1'b1;
    for (int j = 1; j <= 2; j++) begin
      step();
      chk($sformatf("rel_wait%0d", j), outs(),
          pk(4'h0, 4'h0, 4'h0, 1'b0));
    end
    step();
    chk("rel_rise", outs(), pk(4'hF, 4'hF, 4'h0, 1'b1));
    step();
    chk("rel_after", outs(), pk(4'hF, 4'h0, 4'h0, 1'b0));

    // Random stimulus against the model.
    do_reset(4'h0, 4'($urandom_range(15)));
    for (int j = 0; j < 800; j++) begin
      if ($urandom_range(3) == 0) ASYNC = ASYNC ^ 4'($urandom_range(15));
      if ($urandom_range(30) == 0) FILT_EN = 4'($urandom_range(15));
      step();
      chk("rand", outs(), pk(m_sync, m_rise, m_fall, m_chg));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_sync_filt.md
# bit_sync_filt

Multi-channel asynchronous-input synchronizer with a per-channel glitch filter and edge-pulse generation. Each bit of an asynchronous bus passes through an N-flop synchronizer in the CLK domain. It then optionally passes through a stability filter and produces a registered clean level plus single-cycle rise and fall pulses. It sits at clock-domain and pad boundaries: line-state inputs, pin straps, and quasi-static controls feeding host-controller FSMs that need both levels and edge events.

## Interface
- NUM_STAGES, default 2: synchronizer flops per channel; values below 2 are an elaboration error.
- BUS_WIDTH, default 4: number of independent channels; minimum 1.
- FILT_CYCLES, default 4: consecutive stable cycles required before the filtered output changes; minimum 1. Counter width is max(1, $clog2(FILT_CYCLES)).
- RST_VAL, default {BUS_WIDTH{1'b0}}: per-channel reset value of the synchronizer stages and of SYNC.
- CLK  input  1  destination clock; all state updates on its rising edge.
- RST  input  1  reset RST, asynchronous, active-low.
- ASYNC  input  BUS_WIDTH  asynchronous inputs, one independent channel per bit.
- FILT_EN  input  BUS_WIDTH  per-channel filter enable, CLK-synchronous and quasi-static. 0 means bypass: SYNC tracks the synchronizer output.
- SYNC  output  BUS_WIDTH  registered, filtered level per channel.
- RISE  output  BUS_WIDTH  one-cycle pulse in the cycle SYNC[i] becomes 1.
- FALL  output  BUS_WIDTH  one-cycle pulse in the cycle SYNC[i] becomes 0.
- CHG  output  1  registered OR over all channels of (RISE | FALL).

## Operation
**Per channel i, synchronizer**
- Shift register sync[i][NUM_STAGES-1:0] shifts in ASYNC[i] every cycle.
- raw[i] = sync[i][NUM_STAGES-1]. No logic sits between synchronizer stages.

**Per channel i, filter**
- Counter cnt[i].
- FILT_EN[i]=0: SYNC[i] <= raw[i] every cycle; cnt[i] <= 0.
- FILT_EN[i]=1, raw[i]==SYNC[i]: cnt[i] <= 0.
- FILT_EN[i]=1, raw[i]!=SYNC[i], cnt[i] < FILT_CYCLES-1: cnt[i] <= cnt[i]+1.
- FILT_EN[i]=1, raw[i]!=SYNC[i], cnt[i] == FILT_CYCLES-1: SYNC[i] <= raw[i]; cnt[i] <= 0.
- FILT_CYCLES=1 behaves identically to bypass.

**Per channel i, edge outputs**
- RISE[i] <= 1 exactly on the edge where SYNC[i] is loaded 0->1; otherwise 0.
- FALL[i] <= 1 exactly on the edge where SYNC[i] is loaded 1->0; otherwise 0.
- RISE[i] and FALL[i] are never high together.

**CHG**
- CHG <= |(next RISE | next FALL), so it is high in the same cycle as any pulse.

**Channel independence**
- Channels share no state.

**Boundary conditions**
- A raw glitch shorter than FILT_CYCLES cycles clears cnt and produces no SYNC change and no pulse.
- FILT_EN[i] 1->0 mid-count: cnt is cleared and SYNC[i] follows raw on the next edge, with a pulse if it changes.
- FILT_EN[i] 0->1: counting starts from 0.
- ASYNC differing from RST_VAL at reset release: after normal latency, SYNC changes and the corresponding RISE/FALL fires. This is intended.
- Reset asserted mid-count or mid-pulse: everything clears immediately and no pulse is emitted.

## Timing
**Reset values**
- sync[i] = all RST_VAL[i]; cnt = 0; SYNC = RST_VAL; RISE = 0; FALL = 0; CHG = 0.

**Latency**
- ASYNC transition first captured at edge k (setup met).
- raw changes after edge k+NUM_STAGES-1.
- Bypass: SYNC, RISE/FALL and CHG change at edge k+NUM_STAGES.
- Filtered: they change at edge k+NUM_STAGES+FILT_CYCLES-1, provided raw stays stable throughout.
- Metastability resolution adds up to ±1 cycle of input uncertainty. Benches compare with that tolerance only where ASYNC truly violates setup.

**Throughput**
- Bypass: a new level every cycle.
- Filtered: at most one SYNC change per FILT_CYCLES cycles.

## Test plan
Configuration: NUM_STAGES=2, BUS_WIDTH=4, FILT_CYCLES=3, RST_VAL=4'b0000.

- **Bypass rise:** FILT_EN=0; ASYNC[0] 0->1 before edge 10.
  -> SYNC[0]=1, RISE[0]=1 and CHG=1 after edge 12, for exactly one cycle; other channels stay 0.
- **Filtered rise:** FILT_EN=4'hF; ASYNC[1] 0->1 before edge 10, held.
  -> SYNC[1]=1 and RISE[1]=1 after edge 14; RISE[1]=0 after edge 15.
- **Glitch rejection:** FILT_EN=4'hF; ASYNC[2] high for 2 cycles, then low.
  -> SYNC[2], RISE and FALL remain 0 throughout; cnt[2] returns to 0.
- **Simultaneous edges:** ASYNC 4'b0011->4'b1100 with FILT_EN=0, starting from settled SYNC=4'b0011.
  -> after edge k+2: RISE=4'b1100, FALL=4'b0011, SYNC=4'b1100, CHG=1 for one cycle.
- **Filter disable mid-count:** ASYNC[3] rises; FILT_EN[3] goes 1->0 one cycle after raw[3] changes.
  -> SYNC[3]=1 and RISE[3]=1 on the next edge; no second pulse.
- **Reset mid-operation:** RST low while cnt[1]=1 and a RISE pulse is high.
  -> outputs go to 0 immediately. After release with ASYNC=4'b1111 and FILT_EN=0, RISE=4'b1111 fires once, 2 edges after release.
